lopd_pipe: RTL and testbench
============================

// Module: lopd_pipe
// PURPOSE
// Pipelined, multi-lane leading-one position detector (floor(log2(x))) with a valid/ready stream handshake.
// Per lane it returns the leading-one position, a zero flag and the input left-normalised so its leading one sits at the MSB.
// Feeds the integer log2/sqrt/reciprocal approximations in the softmax and layernorm datapaths.
// Replaces the single-lane, fixed 32-bit combinational detector.
// PARAMETERS
// D_W    32  data width per lane; power of two, 8..64
// SEG_W  8   segment width for stage-1 encoders; power of two, divides D_W, SEG_W < D_W
// LANES  4   independent lanes sharing one handshake
// TAG_W  8   sideband tag width, passed through unchanged (TAG_W >= 1)
// PORTS
// clk        in   1                  clock
// rst        in   1                  synchronous reset, active-high
// in_valid   in   1                  input beat valid
// in_ready   out  1                  pipeline can accept a beat
// in_data    in   LANES*D_W          lane l = bits [l*D_W +: D_W]
// in_tag     in   TAG_W              sideband tag
// out_valid  out  1                  result beat valid
// out_ready  in   1                  downstream accepts result
// out_pos    out  LANES*$clog2(D_W)  leading-one index per lane
// out_zero   out  LANES              lane input was all zeros
// out_norm   out  LANES*D_W          lane input << (D_W-1-pos)
// out_tag    out  TAG_W              tag of this beat
// BEHAVIOUR
// - Three register stages S1..S3, each with its own valid bit. Latency is exactly 3 cycles from an accepted beat to out_valid with no backpressure.
// - Throughput is 1 beat/cycle.
// - Stage k advances when it is empty or stage k+1 advances. S3 advances when !out_valid or out_ready.
// - in_ready = S1 advances. This is a bubble-collapsing pipeline; beats are never dropped or duplicated.
// - Beat accepted iff in_valid & in_ready. Outputs hold stable while out_valid & !out_ready.
// - S1: per segment, register seg_any (OR of bits) and seg_pos (local leading-one index, 0 if empty). Also register the data and the tag.
// - S2: the highest non-empty segment s gives pos = s*SEG_W + seg_pos[s]; zero = no segment non-empty. Register pos, zero, data and tag.
// - S3: norm = data << (D_W-1-pos), computed as a logical shift with zero-fill. Register all outputs.
// - Zero input: pos=0, zero=1, norm=0. Note pos=0 also for input 1; zero disambiguates the two cases.
// - Lanes are fully independent. Tag and lane order are preserved.
// - Reset: all stage valids=0, out_valid=0, out_pos=0, out_zero=0, out_norm=0, out_tag=0, in_ready=1 from the first cycle after reset.
// - Reset mid-operation: all in-flight beats are discarded, with no output pulse.
// - Data registers need not be reset, but the outputs must read 0 after reset.
// - When S3 is full and stalled, the upstream stages keep filling until all three are full, then in_ready=0.
// - A beat accepted on the same cycle that out_ready releases a stall proceeds normally.
// - No X may propagate to out_* when out_valid=0 after reset.
// STRUCTURE
// - Package lopd_pkg holds:
//   - localparams POS_W=$clog2(D_W), NSEG=D_W/SEG_W, SPOS_W=$clog2(SEG_W);
//   - a function lz_shift(pos) returning D_W-1-pos;
//   - a typedef lopd_res_t {pos, zero, norm} as a parametrised struct.
// - Sub-module lopd_seg: a combinational priority encoder over SEG_W bits producing {any, pos}.
//   It is instantiated LANES*NSEG times in S1.
// - Keep the S2 segment merge as a for-loop priority scan, not a hardcoded ternary chain.
// TESTING
// (D_W=32, SEG_W=8, LANES=4, TAG_W=8 unless stated)
// 1. in_data lanes {0x80000000, 0x00000001, 0x00000000, 0x00012345}, tag 0x5A, out_ready=1
//    -> 3 cycles later: pos {31,0,0,16}, zero {0,0,1,0}, norm {0x80000000, 0x80000000, 0, 0x91A28000}, tag 0x5A.
// 2. Stream 100 random beats with out_ready=1 and in_valid held high
//    -> out_valid continuous after 3 cycles, results match the golden floor(log2), in order, with no gaps.
// 3. Hold out_ready=0 and push beats
//    -> exactly 3 beats are accepted, then in_ready=0 and outputs stay stable.
//    Raise out_ready -> the 3 beats drain in order with no loss.
// 4. Random in_valid/out_ready toggling (50%) over 10k beats
//    -> the scoreboard sees every beat exactly once, with correct tags.
// 5. Assert rst for 1 cycle with 2 beats in flight
//    -> next cycle out_valid=0 and all outputs 0, in_ready=1; the flushed beats never appear.
// 6. Parameter sweep D_W=16/SEG_W=4 and D_W=64/SEG_W=16, each with every single-bit input 1<<k
//    -> pos=k, norm=MSB only.

Source files
------------

// File: rtl/lopd_pkg.sv
// Shared definitions for the leading-one position detector pipeline.
// The defaults here match the softmax/layernorm datapath configuration.
package lopd_pkg;

  localparam int unsigned LOPD_D_W   = 32;
  localparam int unsigned LOPD_SEG_W = 8;
  localparam int unsigned LOPD_LANES = 4;
  localparam int unsigned LOPD_TAG_W = 8;

  localparam int unsigned POS_W  = $clog2(LOPD_D_W);
  localparam int unsigned NSEG   = LOPD_D_W / LOPD_SEG_W;
  localparam int unsigned SPOS_W = $clog2(LOPD_SEG_W);

  // Left-shift amount that moves bit 'pos' up to the MSB of a d_w-bit word.
  function automatic int unsigned lz_shift(input int unsigned pos, input int unsigned d_w);
    return d_w - 1 - pos;
  endfunction

  typedef struct packed {
    logic [POS_W-1:0]    pos;
    logic                zero;
    logic [LOPD_D_W-1:0] norm;
  } lopd_res_t;

endpackage

// File: rtl/lopd_seg.sv
// Combinational priority encoder for one segment: any-bit flag and
// index of the highest set bit (0 when the segment is empty).
module lopd_seg
  import lopd_pkg::*;
#(
  parameter int unsigned SEG_W = LOPD_SEG_W
) (
  input  logic [SEG_W-1:0]         seg,
  output logic                     any,
  output logic [$clog2(SEG_W)-1:0] pos
);

  localparam int unsigned SP_W = $clog2(SEG_W);

  always_comb begin
    any = |seg;
    pos = '0;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      if (seg[i]) pos = SP_W'(i);
    end
  end

endmodule

// File: rtl/lopd_pipe.sv
// Three-stage, multi-lane leading-one detector with a bubble-collapsing
// valid/ready pipeline: segment encode, segment merge, normalise.
module lopd_pipe
  import lopd_pkg::*;
#(
  parameter int unsigned D_W   = LOPD_D_W,
  parameter int unsigned SEG_W = LOPD_SEG_W,
  parameter int unsigned LANES = LOPD_LANES,
  parameter int unsigned TAG_W = LOPD_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*D_W-1:0]          in_data,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*$clog2(D_W)-1:0]  out_pos,
  output logic [LANES-1:0]              out_zero,
  output logic [LANES*D_W-1:0]          out_norm,
  output logic [TAG_W-1:0]              out_tag
);

  localparam int unsigned P_W   = $clog2(D_W);
  localparam int unsigned N_SEG = D_W / SEG_W;
  localparam int unsigned SP_W  = $clog2(SEG_W);

  typedef struct packed {
    logic [P_W-1:0] pos;
    logic           zero;
    logic [D_W-1:0] norm;
  } res_t;

  logic v1, v2;
  logic adv1, adv2, adv3;

  logic [N_SEG-1:0] seg_any_c [LANES];
  logic [SP_W-1:0]  seg_pos_c [LANES][N_SEG];

  logic [N_SEG-1:0] s1_any  [LANES];
  logic [SP_W-1:0]  s1_pos  [LANES][N_SEG];
  logic [D_W-1:0]   s1_data [LANES];
  logic [TAG_W-1:0] s1_tag;

  logic [P_W-1:0]   s2_pos_c [LANES];
  logic [LANES-1:0] s2_zero_c;
  logic [P_W-1:0]   s2_pos   [LANES];
  logic [LANES-1:0] s2_zero;
  logic [D_W-1:0]   s2_data  [LANES];
  logic [TAG_W-1:0] s2_tag;

  res_t s3_c [LANES];

  // Each stage may move whenever the stage below it frees up in the same cycle.
  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (adv1) v1        <= in_valid;
      if (adv2) v2        <= v1;
      if (adv3) out_valid <= v2;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar s = 0; s < N_SEG; s++) begin : g_seg
      lopd_seg #(.SEG_W(SEG_W)) u_seg (
        .seg (in_data[l*D_W + s*SEG_W +: SEG_W]),
        .any (seg_any_c[l][s]),
        .pos (seg_pos_c[l][s])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        s1_data[l] <= in_data[l*D_W +: D_W];
        s1_any[l]  <= seg_any_c[l];
        s1_pos[l]  <= seg_pos_c[l];
      end
      s1_tag <= in_tag;
    end
  end

  // Ascending scan: the last non-empty segment seen is the highest one.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      s2_pos_c[l]  = '0;
      s2_zero_c[l] = 1'b1;
      for (int unsigned s = 0; s < N_SEG; s++) begin
        if (s1_any[l][s]) begin
          s2_pos_c[l]  = P_W'(s * SEG_W) + P_W'(s1_pos[l][s]);
          s2_zero_c[l] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv2 && v1) begin
      s2_pos  <= s2_pos_c;
      s2_zero <= s2_zero_c;
      s2_data <= s1_data;
      s2_tag  <= s1_tag;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      s3_c[l] = '{pos:  s2_pos[l],
                  zero: s2_zero[l],
                  norm: s2_data[l] << lz_shift(32'(s2_pos[l]), D_W)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pos  <= '0;
      out_zero <= '0;
      out_norm <= '0;
      out_tag  <= '0;
    end else if (adv3 && v2) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        out_pos[l*P_W +: P_W]  <= s3_c[l].pos;
        out_zero[l]            <= s3_c[l].zero;
        out_norm[l*D_W +: D_W] <= s3_c[l].norm;
      end
      out_tag <= s2_tag;
    end
  end

endmodule

// File: tb/tb_lopd_pipe.sv
// Directed and scoreboarded checks for lopd_pipe, plus single-bit sweeps
// on the 16/4 and 64/16 configurations.
module tb_lopd_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_norm;
  logic [7:0]   in_tag, out_tag;
  logic [19:0]  out_pos;
  logic [3:0]   out_zero;

  logic        iv16, ir16, ov16, oz16, it16, ot16;
  logic [15:0] d16, n16;
  logic [3:0]  p16;
  logic        iv64, ir64, ov64, oz64, it64, ot64;
  logic [63:0] d64, n64;
  logic [5:0]  p64;

  lopd_pipe #(.D_W(32), .SEG_W(8), .LANES(4), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_pos(out_pos), .out_zero(out_zero),
    .out_norm(out_norm), .out_tag(out_tag));

  lopd_pipe #(.D_W(16), .SEG_W(4), .LANES(1), .TAG_W(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .in_data(d16), .in_tag(it16), .out_valid(ov16), .out_ready(1'b1),
    .out_pos(p16), .out_zero(oz16), .out_norm(n16), .out_tag(ot16));

  lopd_pipe #(.D_W(64), .SEG_W(16), .LANES(1), .TAG_W(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .in_data(d64), .in_tag(it64), .out_valid(ov64), .out_ready(1'b1),
    .out_pos(p64), .out_zero(oz64), .out_norm(n64), .out_tag(ot64));

  typedef struct {
    logic [19:0]  pos;
    logic [3:0]   zero;
    logic [127:0] norm;
    logic [7:0]   tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   sb_on    = 1'b0;
  int   n_out    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [127:0] d, input logic [7:0] t);
    exp_t e;
    e.pos = '0; e.zero = '0; e.norm = '0; e.tag = t;
    for (int l = 0; l < 4; l++) begin
      logic [31:0] x;
      int p;
      x = d[l*32 +: 32];
      p = 0;
      for (int b = 0; b < 32; b++) if (x[b]) p = b;
      e.pos[l*5 +: 5]    = 5'(p);
      e.zero[l]          = (x == 32'h0);
      e.norm[l*32 +: 32] = x << (31 - p);
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    int unsigned s;
    s = $urandom_range(0, 32);
    return (s == 32) ? 32'h0 : ($urandom >> s);
  endfunction

  function automatic logic [127:0] rnd_beat();
    return {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
  endfunction

  // Samples the handshake mid-cycle, scores it, then advances one clock.
  task automatic tick(output bit acc);
    bit   con;
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    if (sb_on && con) begin
      if (sb.size() == 0) check("unexpected_beat", 128'(1), 128'(0));
      else begin
        e = sb.pop_front();
        check("pos",  128'(out_pos),  128'(e.pos));
        check("zero", 128'(out_zero), 128'(e.zero));
        check("norm", out_norm,       e.norm);
        check("tag",  128'(out_tag),  128'(e.tag));
        n_out++;
      end
    end
    if (sb_on && acc) sb.push_back(model(in_data, in_tag));
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_pos"},   128'(out_pos),   128'(0));
    check({tag, "_zero"},  128'(out_zero),  128'(0));
    check({tag, "_norm"},  out_norm,        128'(0));
    check({tag, "_tag"},   128'(out_tag),   128'(0));
    check({tag, "_ready"}, 128'(in_ready),  128'(1));
  endtask

  initial begin
    bit acc;
    int gaps, nacc, cyc, pulses;
    bit started;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_tag = '0;
    iv16 = 1'b0; d16 = '0; it16 = 1'b0; iv64 = 1'b0; d64 = '0; it64 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // Directed beat with hand-computed results and exact 3-cycle latency.
    in_data  = {32'h00012345, 32'h00000000, 32'h00000001, 32'h80000000};
    in_tag   = 8'h5A;
    in_valid = 1'b1;
    tick(acc);
    check("t1_accept", 128'(acc), 128'(1));
    in_valid = 1'b0;
    check("t1_lat1", 128'(out_valid), 128'(0));
    tick(acc);
    check("t1_lat2", 128'(out_valid), 128'(0));
    tick(acc);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_pos",  128'(out_pos),  128'({5'd16, 5'd0, 5'd0, 5'd31}));
    check("t1_zero", 128'(out_zero), 128'(4'b0100));
    check("t1_norm", out_norm, {32'h91A28000, 32'h00000000, 32'h80000000, 32'h80000000});
    check("t1_tag",  128'(out_tag),  128'(8'h5A));
    tick(acc);
    check("t1_done", 128'(out_valid), 128'(0));

    // Continuous stream: no gaps once the first result appears.
    sb_on = 1'b1; n_out = 0; gaps = 0; nacc = 0; started = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 110 && n_out < 100; i++) begin
      if (nacc < 100) begin in_data = rnd_beat(); in_tag = 8'(i); end
      else in_valid = 1'b0;
      if (out_valid) started = 1'b1;
      else if (started) gaps++;
      tick(acc);
      if (acc) nacc++;
    end
    check("t2_count", 128'(n_out), 128'(100));
    check("t2_gaps",  128'(gaps),  128'(0));
    in_valid = 1'b0;

    // Stall: exactly three beats fill the pipe, outputs hold on the oldest.
    out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
    in_data = rnd_beat(); in_tag = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      if (acc) begin nacc++; in_data = rnd_beat(); in_tag = 8'(8'hC0 + nacc); end
      if (i >= 3) begin
        check("t3_ready", 128'(in_ready),  128'(0));
        check("t3_valid", 128'(out_valid), 128'(1));
        check("t3_hold_norm", out_norm, sb[0].norm);
        check("t3_hold_tag",  128'(out_tag), 128'(sb[0].tag));
      end
    end
    check("t3_accepted", 128'(nacc), 128'(3));
    in_valid = 1'b0; out_ready = 1'b1; n_out = 0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(acc);
    check("t3_drained", 128'(n_out), 128'(3));

    // Random handshake toggling; scoreboard sees every beat exactly once.
    n_out = 0; nacc = 0; cyc = 0;
    while (nacc < 10000 && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rnd_beat();
      in_tag    = 8'($urandom);
      tick(acc);
      if (acc) nacc++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(acc);
    check("t4_accepted", 128'(nacc),  128'(10000));
    check("t4_consumed", 128'(n_out), 128'(10000));
    check("t4_sb_empty", 128'(sb.size()), 128'(0));

    // Reset with two beats in flight: they must never emerge.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin in_data = rnd_beat(); in_tag = 8'(8'hE0 + i); tick(acc); end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    sb.delete();
    check_idle("t5");
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) pulses++;
      tick(acc);
    end
    check("t5_pulses", 128'(pulses), 128'(0));
    sb_on = 1'b0;

    // Single-bit sweeps on the alternate configurations.
    for (int i = 0; i < 67; i++) begin
      iv16 = (i < 16); iv64 = (i < 64);
      d16 = (i < 16) ? (16'd1 << i) : 16'd0;
      d64 = (i < 64) ? (64'd1 << i) : 64'd0;
      tick(acc);
      if (i >= 2 && i - 2 < 16) begin
        check("sw16_valid", 128'(ov16), 128'(1));
        check("sw16_pos",   128'(p16),  128'(i - 2));
        check("sw16_zero",  128'(oz16), 128'(0));
        check("sw16_norm",  128'(n16),  128'(16'h8000));
      end
      if (i >= 2 && i - 2 < 64) begin
        check("sw64_valid", 128'(ov64), 128'(1));
        check("sw64_pos",   128'(p64),  128'(i - 2));
        check("sw64_zero",  128'(oz64), 128'(0));
        check("sw64_norm",  128'(n64),  128'(64'h8000_0000_0000_0000));
      end
    end
    iv16 = 1'b0; iv64 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
